// File: rtl/dbg_pkg.sv
// Shared definitions for the dbg_uart debug/POST peripheral: register map,
// status/control bit positions, TX state encoding and baud divider helper.
package dbg_pkg;

    localparam logic [2:0] DBG_REG_DATA = 3'd0;
    localparam logic [2:0] DBG_REG_STAT = 3'd1;
    localparam logic [2:0] DBG_REG_POST = 3'd2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVF  = 2;

    localparam int CTRL_CLR_OVF = 0;
    localparam int CTRL_FLUSH   = 1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Cycles per serial bit, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/dbg_uart_if.sv
// CPU-side I/O bus of the debug peripheral (active-low strobes and select).
interface dbg_uart_if;

    logic       IO_DBG;
    logic       WR;
    logic       RD;
    logic [2:0] ADDR;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;
    logic       DATA_OE;

    modport master (
        output IO_DBG, WR, RD, ADDR, DATA_IN,
        input  DATA_OUT, DATA_OE
    );

    modport slave (
        input  IO_DBG, WR, RD, ADDR, DATA_IN,
        output DATA_OUT, DATA_OE
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush. push is accepted only when not full and pop only
// when not empty; flush overrides both in the same cycle and empties the FIFO.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are AW bits and wrap naturally; level carries the extra bit.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/dbg_uart.sv
// Debug/POST peripheral: CPU writes queue bytes for an 8N1 transmitter and
// latch a POST code for the LEDs. Bus strobes are synchronised into clk.
module dbg_uart
    import dbg_pkg::*;
#(
    parameter int CLK_HZ     = 60_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       RESET,
    dbg_uart_if.slave  bus,
    output logic       TXD,
    output logic [7:0] POST_LED,
    output tx_state_e  dbg_state
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int DW  = $clog2(DIV);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;

    // Bus strobe synchronisers and write edge detect
    logic [1:0] cs_sync;
    logic [1:0] wr_sync;
    logic       wr_prev;
    logic       wr_fire;
    logic       wr_data;
    logic       wr_ctrl;
    logic       wr_post;
    logic       flush_req;
    logic       clr_ovf;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            cs_sync <= 2'b11;
            wr_sync <= 2'b11;
            wr_prev <= 1'b1;
        end else begin
            cs_sync <= {cs_sync[0], bus.IO_DBG};
            wr_sync <= {wr_sync[0], bus.WR};
            wr_prev <= wr_sync[1];
        end
    end

    // ADDR/DATA_IN are held stable by the CPU for the whole strobe, so they
    // are safe to sample directly on the firing cycle.
    assign wr_fire   = ~wr_sync[1] & wr_prev & ~cs_sync[1];
    assign wr_data   = wr_fire & (bus.ADDR == DBG_REG_DATA);
    assign wr_ctrl   = wr_fire & (bus.ADDR == DBG_REG_STAT);
    assign wr_post   = wr_fire & (bus.ADDR == DBG_REG_POST);
    assign flush_req = wr_ctrl & bus.DATA_IN[CTRL_FLUSH];
    assign clr_ovf   = wr_ctrl & bus.DATA_IN[CTRL_CLR_OVF];

    // TX FIFO
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .RESET (RESET),
        .push  (wr_data),
        .wdata (bus.DATA_IN),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .flush (flush_req),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Overflow flag and POST register
    logic overflow;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            overflow <= 1'b0;
            POST_LED <= 8'h00;
        end else begin
            if (wr_post) begin
                POST_LED <= bus.DATA_IN;
            end
            if (clr_ovf) begin
                overflow <= 1'b0;
            end else if (wr_data & fifo_full & ~flush_req) begin
                overflow <= 1'b1;
            end
        end
    end

    // TX FSM
    tx_state_e     state;
    tx_state_e     state_nxt;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_nxt;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_cnt_nxt;
    logic          bit_end;
    logic          tx_ready;

    assign bit_end  = (div_cnt == DW'(DIV - 1));
    // A flush in the same cycle must not let a queued byte escape into a frame.
    assign tx_ready = ~fifo_empty & ~flush_req;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state   <= TX_IDLE;
            shreg   <= 8'h00;
            bit_cnt <= 3'd0;
            div_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            div_cnt <= div_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        div_cnt_nxt = div_cnt;
        fifo_pop    = 1'b0;

        if (state != TX_IDLE) begin
            div_cnt_nxt = bit_end ? '0 : div_cnt + DW'(1);
        end

        case (state)
            TX_IDLE: begin
                if (tx_ready) begin
                    fifo_pop    = 1'b1;
                    shreg_nxt   = fifo_rdata;
                    div_cnt_nxt = '0;
                    state_nxt   = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    bit_cnt_nxt = 3'd0;
                    state_nxt   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    shreg_nxt   = {1'b0, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                // Next byte goes straight into its start bit: no idle gap.
                if (bit_end) begin
                    if (tx_ready) begin
                        fifo_pop  = 1'b1;
                        shreg_nxt = fifo_rdata;
                        state_nxt = TX_START;
                    end else begin
                        state_nxt = TX_IDLE;
                    end
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    // Decoded from registered state so reset forces the line high at once.
    always_comb begin
        TXD = 1'b1;
        case (state)
            TX_START: TXD = 1'b0;
            TX_DATA:  TXD = shreg[0];
            default:  TXD = 1'b1;
        endcase
    end

    assign dbg_state = state;

    // Read path
    logic busy;

    assign busy        = (state != TX_IDLE) | ~fifo_empty;
    assign bus.DATA_OE = ~bus.IO_DBG & ~bus.RD;

    always_comb begin
        bus.DATA_OUT = 8'h00;
        case (bus.ADDR)
            DBG_REG_DATA: bus.DATA_OUT = 8'(fifo_level);
            DBG_REG_STAT: begin
                bus.DATA_OUT[STAT_BUSY] = busy;
                bus.DATA_OUT[STAT_FULL] = fifo_full;
                bus.DATA_OUT[STAT_OVF]  = overflow;
            end
            DBG_REG_POST: bus.DATA_OUT = POST_LED;
            default:      bus.DATA_OUT = 8'h00;
        endcase
    end

endmodule

// File: doc/dbg_uart.md
# dbg_uart

Debug/POST peripheral behind the chipset's `IO_DBG` select (I/O 0x010–0x017). CPU `OUT` writes queue bytes into a 16-entry FIFO that a 115200-baud 8N1 transmitter drains; a separate POST-code register drives eight LEDs. Bus strobes arrive asynchronously from the CPU clock domain. They are synchronised into `clk`, which is the 60 MHz board clock the chipset also uses.

## Interface
- `CLK_HZ`, 60_000_000, frequency of `clk`.
- `BAUD`, 115200, serial bit rate; `DIV = (CLK_HZ + BAUD/2) / BAUD` cycles per bit (521 at default).
- `FIFO_DEPTH`, 16, TX FIFO entries; must be a power of two.
- `clk`  in  1  board clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `IO_DBG`  in  1  active-low chip select from the chipset decoder.
- `WR`  in  1  active-low CPU write strobe.
- `RD`  in  1  active-low CPU read strobe.
- `ADDR`  in  3  register offset (`ADDR[2:0]`).
- `DATA_IN`  in  8  write data (low byte of `DATA`).
- `DATA_OUT`  out  8  read data.
- `DATA_OE`  out  1  high while `~IO_DBG & ~RD`; combinational.
- `TXD`  out  1  serial output, idle high.
- `POST_LED`  out  8  POST-code register contents.

## Operation
- Offset 0, write: push `DATA_IN` into the FIFO. If the FIFO is full, drop the byte and set `overflow`.
- Offset 0, read: returns FIFO level in bits [4:0]; other bits read 0.
- Offset 1, write: bit0=1 clears `overflow`; bit1=1 flushes the FIFO (level→0). An in-flight frame completes.
- Offset 1, read: status `{5'b0, overflow, full, busy}`. `busy` = FSM not IDLE or FIFO non-empty.
- Offset 2, write: latch `POST_LED`. Offset 2, read: current `POST_LED`.
- Offsets 3–7: writes ignored; reads return 8'h00.
- Reads have no side effects. `DATA_OUT` is a combinational mux of `ADDR` and registered state.
- Write capture:
  - `IO_DBG` and `WR` each pass through a 2-flop synchroniser.
  - A write fires on the first cycle where synchronised `WR` is low and was high the previous cycle, with synchronised `IO_DBG` low.
  - `ADDR` and `DATA_IN` are sampled unsynchronised on that cycle. The CPU holds them stable for the whole strobe, which is ≥150 ns.
  - Exactly one action per strobe.
- TX FSM states:
  - IDLE: if FIFO non-empty, pop into shift register and go to START.
  - START: `TXD`=0 for `DIV` cycles, then DATA.
  - DATA: 8 bits LSB first, `DIV` cycles each, then STOP.
  - STOP: `TXD`=1 for `DIV` cycles. Then, if FIFO non-empty, pop and go to START directly (no idle gap); otherwise go to IDLE.
- Push and pop in the same cycle: level unchanged; both take effect.
- A push that finds the FIFO full is dropped even if a pop occurs in the same cycle.
- Flush and push in the same cycle: flush wins; the byte is discarded, and `overflow` is not set.
- FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap naturally. Level is one bit wider (0..16).

## Timing
- Reset values: `TXD`=1, `POST_LED`=8'h00, FIFO empty, `overflow`=0, FSM=IDLE, bit counter=0, divider=0.
- Reset mid-frame: `TXD` returns high immediately (asynchronously). The partial byte and FIFO contents are lost.
- Write latency: falling `WR` → register or FIFO update at the 3rd rising `clk` edge after the fall (2 sync + edge detect).
- Push → start bit: from IDLE, `TXD` falls 1 cycle after the push edge.
- Frame length: exactly `10*DIV` cycles. Back-to-back frames are contiguous.
- `full`, `level` and `busy` reflect registered state; visible to a read the cycle after the update.

## Structure
- Shared package/include `dbg_pkg`:
  - register offsets (`DBG_REG_DATA`=0, `DBG_REG_STAT`=1, `DBG_REG_POST`=2);
  - status bit positions;
  - FSM state encoding (IDLE/START/DATA/STOP);
  - `DIV` computation function.
- One sub-module, `sync_fifo`, parameterised by width and depth: push, pop, flush, full, empty, level.
- Synchronisers, decode and the TX FSM stay in `dbg_uart`.

## Test plan
- Reset: assert `RESET` mid-frame (bench `CLK_HZ`=1_000_000, `BAUD`=100_000, `DIV`=10) → `TXD`=1 within the same cycle, status reads 8'h00, `POST_LED`=8'h00.
- Single byte: write 8'hA5 to offset 0 → `TXD` low 1 cycle after push; bits 1,0,1,0,0,1,0,1 at 10-cycle spacing; stop high; status `busy` clears after 100 cycles.
- Back-to-back: write 8'h55 then 8'h0F → 200 contiguous cycles, no idle gap between stop and the second start bit.
- Overflow: write 17 bytes quickly while the first is transmitting → level=16, 17th dropped, status bit2=1; write 8'h01 to offset 1 → bit2=0.
- Flush: queue 5 bytes, write 8'h02 to offset 1 mid-frame → current frame completes, no further frames, level=0.
- POST/decode: write 8'h3C to offset 2 → `POST_LED`=8'h3C; read offset 2 returns 8'h3C with `DATA_OE`=1; read offset 5 returns 8'h00; a write with `IO_DBG` high changes nothing.
